// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request bus between the fetch controller and memory.
// Data returns in the same cycle that ready is asserted.
interface pc_fetch_ctrl_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: one-deep presentation register in front of a
// zero-wait instruction memory, with stall hold and branch/jump redirect.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_in,
    input  logic               redirect_in,
    input  logic [31:0]        redirect_target_in,
    pc_fetch_ctrl_if.master    imem,
    output logic [31:0]        instr_o,
    output logic               instr_valid_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc_plus4_o,
    output logic               misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] fetch_pc_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic        valid_reg;
    logic        misalign_reg;

    logic        hold_now;
    logic        req;
    logic        xfer;

    // A stalled valid instruction blocks fetch so it is never overwritten.
    assign hold_now = stall_in & valid_reg;
    assign req      = (state_reg == REQ) & ~hold_now;
    assign xfer     = req & imem.imem_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            pc_reg       <= RESET_PC;
            instr_reg    <= NOP_INSTR;
            valid_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= 1'b0;
            if (state_reg != IDLE && redirect_in) begin
                // Redirect wins over stall and drops any same-cycle transfer.
                fetch_pc_reg <= {redirect_target_in[31:2], 2'b00};
                valid_reg    <= 1'b0;
                misalign_reg <= |redirect_target_in[1:0];
                state_reg    <= REQ;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= REQ;
                    end
                    REQ: begin
                        if (hold_now) begin
                            state_reg <= HOLD;
                        end else if (xfer) begin
                            instr_reg    <= imem.imem_rdata_i;
                            pc_reg       <= fetch_pc_reg;
                            valid_reg    <= 1'b1;
                            fetch_pc_reg <= fetch_pc_reg + 32'd4;
                        end else begin
                            valid_reg <= 1'b0;
                        end
                    end
                    HOLD: begin
                        // The release edge is where downstream consumes the held word.
                        if (!stall_in) begin
                            state_reg <= REQ;
                            valid_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = fetch_pc_reg;
    assign instr_o          = valid_reg ? instr_reg : NOP_INSTR;
    assign instr_valid_o    = valid_reg;
    assign pc_o             = pc_reg;
    assign pc_plus4_o       = pc_reg + 32'd4;
    assign misalign_o       = misalign_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by random
// stall/redirect/ready traffic, compared against a cycle-level reference model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_target_in;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        misalign_o;
    logic [31:0] rdata_xor;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_in          (stall_in),
        .redirect_in       (redirect_in),
        .redirect_target_in(redirect_target_in),
        .imem              (bus.master),
        .instr_o           (instr_o),
        .instr_valid_o     (instr_valid_o),
        .pc_o              (pc_o),
        .pc_plus4_o        (pc_plus4_o),
        .misalign_o        (misalign_o)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address.
    assign bus.imem_rdata_i = bus.imem_addr_o ^ rdata_xor;

    // Reference model: "started" is false only before the first post-reset edge,
    // "frozen" marks a presented word parked behind a stall.
    logic        m_started, m_frozen, m_valid, m_mis;
    logic [31:0] m_fpc, m_pc, m_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_frozen  = 1'b0;
        m_valid   = 1'b0;
        m_mis     = 1'b0;
        m_fpc     = RESET_PC;
        m_pc      = RESET_PC;
        m_word    = NOP_INSTR;
    endtask

    // Called just after a falling edge: checks the presented state, drives the
    // inputs for the coming rising edge, then advances the model across it.
    task automatic step(input logic s, input logic r, input logic [31:0] t, input logic rdy);
        logic m_req;
        check("valid",    {31'd0, instr_valid_o}, {31'd0, m_valid});
        check("pc",       pc_o,                   m_pc);
        check("instr",    instr_o,                m_valid ? m_word : NOP_INSTR);
        check("pc_plus4", pc_plus4_o,             m_pc + 32'd4);
        check("misalign", {31'd0, misalign_o},    {31'd0, m_mis});
        check("addr",     bus.imem_addr_o,        m_fpc);
        stall_in           = s;
        redirect_in        = r;
        redirect_target_in = t;
        bus.imem_ready_i   = rdy;
        #1;
        m_req = m_started && !m_frozen && !(s && m_valid);
        check("req", {31'd0, bus.imem_req_o}, {31'd0, m_req});
        m_mis = 1'b0;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (r) begin
            m_fpc    = t & 32'hFFFF_FFFC;
            m_valid  = 1'b0;
            m_frozen = 1'b0;
            m_mis    = (t % 4) != 0;
            $display("redirect target=%h", t);
        end else if (m_frozen) begin
            if (!s) begin
                m_frozen = 1'b0;
                m_valid  = 1'b0;
            end
        end else if (s && m_valid) begin
            m_frozen = 1'b1;
        end else if (m_req && rdy) begin
            m_word  = m_fpc ^ rdata_xor;
            m_pc    = m_fpc;
            m_valid = 1'b1;
            $display("fetch addr=%h data=%h", m_fpc, m_word);
            m_fpc   = m_fpc + 32'd4;
        end else begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic async_reset_check();
        rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, instr_valid_o},  32'd0);
        check("rst_req",   {31'd0, bus.imem_req_o}, 32'd0);
        check("rst_mis",   {31'd0, misalign_o},     32'd0);
        check("rst_addr",  bus.imem_addr_o,         RESET_PC);
        check("rst_pc",    pc_o,                    RESET_PC);
        check("rst_pc4",   pc_plus4_o,              RESET_PC + 32'd4);
        check("rst_instr", instr_o,                 NOP_INSTR);
        model_reset();
    endtask

    initial begin
        rst_n              = 1'b0;
        stall_in           = 1'b0;
        redirect_in        = 1'b0;
        redirect_target_in = 32'd0;
        bus.imem_ready_i   = 1'b1;
        rdata_xor          = 32'd0;
        model_reset();

        repeat (2) @(negedge clk);
        async_reset_check();
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Zero-wait streaming from reset, rdata equal to address.
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b1);
        check("stream_pc0",    pc_o, 32'h0);
        check("stream_valid0", {31'd0, instr_valid_o}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("stream_pc4",    pc_o, 32'h4);
        check("stream_addr8",  bus.imem_addr_o, 32'h8);
        step(1'b0, 1'b0, 32'd0, 1'b1);

        // Three stalled cycles with 0x8 presented.
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b1);
        check("hold_pc",    pc_o, 32'h8);
        check("hold_instr", instr_o, 32'h8);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("release_valid", {31'd0, instr_valid_o}, 32'd0);
        check("resume_addr",   bus.imem_addr_o, 32'hC);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("resume_pc", pc_o, 32'hC);
        step(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect coincident with the transfer at 0x14.
        step(1'b0, 1'b1, 32'h200, 1'b1);
        check("redir_valid", {31'd0, instr_valid_o}, 32'd0);
        check("redir_addr",  bus.imem_addr_o, 32'h200);
        check("redir_mis",   {31'd0, misalign_o}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("redir_pc", pc_o, 32'h200);

        // Misaligned target.
        step(1'b0, 1'b1, 32'h103, 1'b1);
        check("mis_high", {31'd0, misalign_o}, 32'd1);
        check("mis_addr", bus.imem_addr_o, 32'h100);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("mis_low", {31'd0, misalign_o}, 32'd0);
        check("mis_pc",  pc_o, 32'h100);

        // Address wrap.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("wrap_pc",   pc_o, 32'hFFFF_FFFC);
        check("wrap_pc4",  pc_plus4_o, 32'h0);
        check("wrap_addr", bus.imem_addr_o, 32'h0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("wrap_pc0", pc_o, 32'h0);

        // Redirect while holding discards the held word.
        repeat (2) step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 32'h40, 1'b1);
        check("hold_redir_valid", {31'd0, instr_valid_o}, 32'd0);
        check("hold_redir_addr",  bus.imem_addr_o, 32'h40);

        // Asynchronous reset in the middle of HOLD.
        step(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 32'd0, 1'b1);
        #2;
        async_reset_check();
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Random traffic.
        rdata_xor = $urandom;
        for (int i = 0; i < 400; i++) begin
            logic        s, r, rdy;
            logic [31:0] t;
            s   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            t   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : ($urandom & 32'h0000_0FFF);
            step(s, r, t, rdy);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
